apu_reg_file: RTL
=================

Name: apu_reg_file

Overview:
- CPU-side register front end for the four sound channels and the mixer.
- Decodes byte writes to the APU register window 0x10–0x3F (low byte of 0xFFxx).
- Holds the per-channel control fields the channel modules consume, plus one-cycle trigger pulses.
- Returns masked read-back data. Sits between the bus/sequencer and pulseChannel1/pulseChannel2/noiseChannel/waveChannel/mixer.

Parameters:
- ADDR_W, 8, bus address width; only the low 8 bits are decoded.
- PWR_RST, 1, reset value of the NR52 power bit.

Ports:
- clk  in  1  system clock (channel base clock)
- rst_n  in  1  asynchronous active-low reset
- addr  in  ADDR_W  register address
- wr_en  in  1  write strobe, sampled at posedge clk
- wr_data  in  8  write data
- rd_en  in  1  read strobe
- rd_data  out  8  read data, registered
- rd_valid  out  1  high one cycle after an accepted rd_en
- ch_on  in  4  channel-active flags {noise, wave, sq2, sq1}, reflected in NR52[3:0]
- sq1_swpPd 3, sq1_negate 1, sq1_shift 3, sq1_duty 2, sq1_lenLoad 6, sq1_startVol 4, sq1_envAdd 1, sq1_period 3, sq1_freq 11, sq1_lenEnable 1, sq1_trig 1  out  square 1 fields
- sq2_duty 2, sq2_lenLoad 6, sq2_startVol 4, sq2_envAdd 1, sq2_period 3, sq2_freq 11, sq2_lenEnable 1, sq2_trig 1  out  square 2 fields
- w_enable 1, w_vol 2, w_lenLoad 6, w_freq 11, w_lenEnable 1, w_trig 1  out  wave fields
- waveTable  out  128  sample i (0..31) at [4i+3:4i]
- n_lenLoad 6, n_startVol 4, n_envAdd 1, n_period 3, n_clkShift 4, n_widthMode 1, n_divisor 3, n_lenEnable 1, n_trig 1  out  noise fields
- volL 3, volR 3, pan 8  out  mixer controls (NR50[6:4], NR50[2:0], NR51)

Behaviour:
- Reset (async, rst_n low): all registers 0x00, wave RAM 0, power = PWR_RST, all trig outputs 0, rd_data 0x00, rd_valid 0. Release is synchronous-safe: the first write is accepted on the first posedge after rst_n rises.
- Write map:
  - 0x10 NR10: [6:4] swpPd, [3] negate, [2:0] shift.
  - 0x11 NR11 / 0x16 NR21: [7:6] duty, [5:0] lenLoad.
  - 0x12 / 0x17 / 0x21: [7:4] startVol, [3] envAdd, [2:0] period.
  - 0x13 / 0x18 / 0x1D: freq[7:0].
  - 0x14 / 0x19 / 0x1E / 0x23: [7] trigger, [6] lenEnable; [2:0] freq[10:8] (not for 0x23).
  - 0x1A: [7] w_enable. 0x1B: 8-bit length stored, w_lenLoad = [5:0]. 0x1C: [6:5] w_vol.
  - 0x20: [5:0] n_lenLoad. 0x22: [7:4] clkShift, [3] widthMode, [2:0] divisor.
  - 0x24 NR50 full byte stored. 0x25 NR51. 0x26 NR52: only [7] writable (power).
  - 0x30–0x3F wave byte k: sample 2k = data[7:4], sample 2k+1 = data[3:0].
- Field outputs update on the same edge that captures the write (zero added latency).
- Trigger: a write of bit7=1 to 0x14/0x19/0x1E/0x23 asserts the matching *_trig high for exactly the following clock cycle; freq/lenEnable from the same write are already visible in that cycle. A trigger bit is never stored.
  - Back-to-back trigger writes produce back-to-back pulses.
- Power off (NR52[7] written 0): registers 0x10–0x25 clear to 0 on that edge.
  - Subsequent writes to 0x10–0x25 are ignored.
  - NR52 and wave RAM remain writable.
  - Triggers are suppressed.
  - Power on leaves the registers at 0.
- Reads: rd_data = stored value | mask, registered, latency 1 cycle.
  - Masks: 10:80 11:3F 12:00 13:FF 14:BF 16:3F 17:00 18:FF 19:BF 1A:7F 1B:FF 1C:9F 1D:FF 1E:BF 20:FF 21:00 22:00 23:BF 24:00 25:00.
  - NR52 = {power, 3'b111, ch_on}.
  - Wave RAM unmasked.
  - Unmapped 0x15, 0x1F, 0x27–0x2F, and any address outside 0x10–0x3F: 0xFF.
- Simultaneous rd_en and wr_en to the same address: read returns the pre-write value.

Optional Feature:
- APU_LEN_WRITE_WHEN_OFF_EN defined: while power is off, writes to the length fields (NR11[5:0], NR21[5:0], NR31, NR41[5:0]) are still accepted; duty bits stay ignored.
- Undefined: all writes to 0x10–0x25 are ignored while power is off.

Decomposition:
- Package apu_reg_pkg:
  - Address constants (NR10..NR52, WAVE_BASE).
  - Per-address read-mask constants.
  - Trigger bit index 7, length-enable bit index 6.
- Sub-module apu_wave_ram: 16x8 storage, one write port, one registered read port, flattened 128-bit sample output.

Test Plan:
- Reset, then write 0x12←0xF3 and read 0x12 → sq1_startVol=15, sq1_envAdd=0, sq1_period=3; rd_data=0xF3 one cycle later with rd_valid=1.
- Write 0x13←0xAB, then 0x14←0xC5 → sq1_freq=0x5AB, sq1_lenEnable=1, sq1_trig high for exactly 1 cycle; read 0x14 → 0xFF.
- Write 0x30←0x1F, 0x3F←0xE0 → samples 0=1, 1=15, 30=14, 31=0; read 0x30 → 0x1F.
- Write 0x26←0x00, then 0x11←0x7F → all fields 0; read 0x26 with ch_on=4'b0101 → 0x75. sq1_lenLoad=0 when macro undefined, 63 when defined.
- Read 0x15 → 0xFF. Simultaneous read/write to 0x24 (old 0x00, new 0x77) → rd_data 0x00; volL=7, volR=7 after the edge.
- Assert rst_n low mid-pulse (cycle right after a trigger write) → sq2_trig drops immediately; all outputs return to reset values.

Source files
------------

// File: rtl/apu_reg_pkg.sv
// APU register window constants: register addresses, read-back masks and the
// bit positions shared by the trigger/length-enable registers.
package apu_reg_pkg;

    localparam logic [7:0] NR10 = 8'h10;
    localparam logic [7:0] NR11 = 8'h11;
    localparam logic [7:0] NR12 = 8'h12;
    localparam logic [7:0] NR13 = 8'h13;
    localparam logic [7:0] NR14 = 8'h14;
    localparam logic [7:0] NR21 = 8'h16;
    localparam logic [7:0] NR22 = 8'h17;
    localparam logic [7:0] NR23 = 8'h18;
    localparam logic [7:0] NR24 = 8'h19;
    localparam logic [7:0] NR30 = 8'h1A;
    localparam logic [7:0] NR31 = 8'h1B;
    localparam logic [7:0] NR32 = 8'h1C;
    localparam logic [7:0] NR33 = 8'h1D;
    localparam logic [7:0] NR34 = 8'h1E;
    localparam logic [7:0] NR41 = 8'h20;
    localparam logic [7:0] NR42 = 8'h21;
    localparam logic [7:0] NR43 = 8'h22;
    localparam logic [7:0] NR44 = 8'h23;
    localparam logic [7:0] NR50 = 8'h24;
    localparam logic [7:0] NR51 = 8'h25;
    localparam logic [7:0] NR52 = 8'h26;
    localparam logic [7:0] WAVE_BASE = 8'h30;

    localparam logic [7:0] REG_LO = NR10;
    localparam logic [7:0] REG_HI = NR51;
    localparam int NUM_REGS = 22;

    localparam int TRIG_BIT   = 7;
    localparam int LEN_EN_BIT = 6;

    localparam logic [7:0] MASK_NR10 = 8'h80;
    localparam logic [7:0] MASK_NR11 = 8'h3F;
    localparam logic [7:0] MASK_NR12 = 8'h00;
    localparam logic [7:0] MASK_NR13 = 8'hFF;
    localparam logic [7:0] MASK_NR14 = 8'hBF;
    localparam logic [7:0] MASK_NR21 = 8'h3F;
    localparam logic [7:0] MASK_NR22 = 8'h00;
    localparam logic [7:0] MASK_NR23 = 8'hFF;
    localparam logic [7:0] MASK_NR24 = 8'hBF;
    localparam logic [7:0] MASK_NR30 = 8'h7F;
    localparam logic [7:0] MASK_NR31 = 8'hFF;
    localparam logic [7:0] MASK_NR32 = 8'h9F;
    localparam logic [7:0] MASK_NR33 = 8'hFF;
    localparam logic [7:0] MASK_NR34 = 8'hBF;
    localparam logic [7:0] MASK_NR41 = 8'hFF;
    localparam logic [7:0] MASK_NR42 = 8'h00;
    localparam logic [7:0] MASK_NR43 = 8'h00;
    localparam logic [7:0] MASK_NR44 = 8'hBF;
    localparam logic [7:0] MASK_NR50 = 8'h00;
    localparam logic [7:0] MASK_NR51 = 8'h00;

    // Unmapped holes inside the window read back as all ones.
    function automatic logic [7:0] read_mask(input logic [7:0] a);
        case (a)
            NR10:    return MASK_NR10;
            NR11:    return MASK_NR11;
            NR12:    return MASK_NR12;
            NR13:    return MASK_NR13;
            NR14:    return MASK_NR14;
            NR21:    return MASK_NR21;
            NR22:    return MASK_NR22;
            NR23:    return MASK_NR23;
            NR24:    return MASK_NR24;
            NR30:    return MASK_NR30;
            NR31:    return MASK_NR31;
            NR32:    return MASK_NR32;
            NR33:    return MASK_NR33;
            NR34:    return MASK_NR34;
            NR41:    return MASK_NR41;
            NR42:    return MASK_NR42;
            NR43:    return MASK_NR43;
            NR44:    return MASK_NR44;
            NR50:    return MASK_NR50;
            NR51:    return MASK_NR51;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_reg_addr(input logic [7:0] a);
        return (a >= REG_LO) && (a <= REG_HI) && (a != 8'h15) && (a != 8'h1F);
    endfunction

    function automatic logic [4:0] reg_index(input logic [7:0] a);
        return 5'(a - REG_LO);
    endfunction

endpackage

// File: rtl/apu_wave_ram.sv
// 16x8 wave sample RAM: one write port, one registered read port and the full
// 32-sample table flattened for the wave channel (sample i at [4i+3:4i]).
module apu_wave_ram (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [3:0]   wr_addr,
    input  logic [7:0]   wr_data,
    input  logic         rd_en,
    input  logic [3:0]   rd_addr,
    output logic [7:0]   rd_data,
    output logic [127:0] samples
);

    logic [7:0] mem [16];

    // NOTE: the RAM is built from flops and the wave channel sees every entry,
    // so it is cleared on reset rather than left undefined like a macro RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            rd_data <= '0;
        end else begin
            if (rd_en) rd_data <= mem[rd_addr];
            if (wr_en) mem[wr_addr] <= wr_data;
        end
    end

    // Byte k holds sample 2k in its high nibble, so the nibbles swap on the way out.
    for (genvar k = 0; k < 16; k++) begin : g_samples
        assign samples[8*k +: 8] = {mem[k][3:0], mem[k][7:4]};
    end

endmodule

// File: rtl/apu_reg_file.sv
// CPU-side APU register front end: decodes 0xFF10-0xFF3F byte writes into the
// channel/mixer control fields, trigger pulses and masked registered read-back.
// Optional: APU_LEN_WRITE_WHEN_OFF_EN keeps length fields writable while powered off.
module apu_reg_file
    import apu_reg_pkg::*;
#(
    parameter int   ADDR_W  = 8,
    parameter logic PWR_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic [3:0]        ch_on,
    output logic [2:0]        sq1_swpPd,
    output logic              sq1_negate,
    output logic [2:0]        sq1_shift,
    output logic [1:0]        sq1_duty,
    output logic [5:0]        sq1_lenLoad,
    output logic [3:0]        sq1_startVol,
    output logic              sq1_envAdd,
    output logic [2:0]        sq1_period,
    output logic [10:0]       sq1_freq,
    output logic              sq1_lenEnable,
    output logic              sq1_trig,
    output logic [1:0]        sq2_duty,
    output logic [5:0]        sq2_lenLoad,
    output logic [3:0]        sq2_startVol,
    output logic              sq2_envAdd,
    output logic [2:0]        sq2_period,
    output logic [10:0]       sq2_freq,
    output logic              sq2_lenEnable,
    output logic              sq2_trig,
    output logic              w_enable,
    output logic [1:0]        w_vol,
    output logic [5:0]        w_lenLoad,
    output logic [10:0]       w_freq,
    output logic              w_lenEnable,
    output logic              w_trig,
    output logic [127:0]      waveTable,
    output logic [5:0]        n_lenLoad,
    output logic [3:0]        n_startVol,
    output logic              n_envAdd,
    output logic [2:0]        n_period,
    output logic [3:0]        n_clkShift,
    output logic              n_widthMode,
    output logic [2:0]        n_divisor,
    output logic              n_lenEnable,
    output logic              n_trig,
    output logic [2:0]        volL,
    output logic [2:0]        volR,
    output logic [7:0]        pan
);

    logic [7:0] a8;
    logic [7:0] regs [NUM_REGS];
    logic       power;
    logic [3:0] trig_q;          // {noise, wave, sq2, sq1}
    logic [3:0] trig_sel;
    logic [4:0] idx;
    logic       reg_hit;
    logic       wave_hit;
    logic [7:0] store_data;

    assign a8       = addr[7:0];
    assign idx      = reg_index(a8);
    assign reg_hit  = is_reg_addr(a8);
    assign wave_hit = (a8[7:4] == WAVE_BASE[7:4]);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        trig_sel = '0;
        case (a8)
            NR14:    trig_sel = 4'b0001;
            NR24:    trig_sel = 4'b0010;
            NR34:    trig_sel = 4'b0100;
            NR44:    trig_sel = 4'b1000;
            default: trig_sel = '0;
        endcase
    end

    assign store_data = (|trig_sel) ? {1'b0, wr_data[6:0]} : wr_data;

`ifdef APU_LEN_WRITE_WHEN_OFF_EN
    logic [7:0] len_mask;

    always_comb begin
        len_mask = '0;
        case (a8)
            NR11, NR21, NR41: len_mask = 8'h3F;
            NR31:             len_mask = 8'hFF;
            default:          len_mask = '0;
        endcase
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            power  <= PWR_RST;
            trig_q <= '0;
        end else begin
            trig_q <= (wr_en && power && reg_hit && wr_data[TRIG_BIT]) ? trig_sel : '0;
            if (wr_en) begin
                if (a8 == NR52) begin
                    power <= wr_data[7];
                    if (!wr_data[7]) begin
                        for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
                    end
                end else if (reg_hit) begin
                    if (power) begin
                        regs[idx] <= store_data;
                    end
`ifdef APU_LEN_WRITE_WHEN_OFF_EN
                    else begin
                        regs[idx] <= (regs[idx] & ~len_mask) | (wr_data & len_mask);
                    end
`endif
                end
            end
        end
    end

    // Read path: register value captured before any same-edge write lands.
    logic [7:0] reg_rd_d;
    logic [7:0] reg_rd_q;
    logic [7:0] wave_rd;
    logic       rd_wave_sel;

    always_comb begin
        reg_rd_d = 8'hFF;
        if (reg_hit) begin
            reg_rd_d = regs[idx] | read_mask(a8);
        end else if (a8 == NR52) begin
            reg_rd_d = {power, 3'b111, ch_on};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rd_q    <= '0;
            rd_wave_sel <= 1'b0;
            rd_valid    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                reg_rd_q    <= reg_rd_d;
                rd_wave_sel <= wave_hit;
            end
        end
    end

    assign rd_data = rd_wave_sel ? wave_rd : reg_rd_q;

    apu_wave_ram u_wave_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && wave_hit),
        .wr_addr (a8[3:0]),
        .wr_data (wr_data),
        .rd_en   (rd_en && wave_hit),
        .rd_addr (a8[3:0]),
        .rd_data (wave_rd),
        .samples (waveTable)
    );

    assign sq1_swpPd     = regs[0][6:4];
    assign sq1_negate    = regs[0][3];
    assign sq1_shift     = regs[0][2:0];
    assign sq1_duty      = regs[1][7:6];
    assign sq1_lenLoad   = regs[1][5:0];
    assign sq1_startVol  = regs[2][7:4];
    assign sq1_envAdd    = regs[2][3];
    assign sq1_period    = regs[2][2:0];
    assign sq1_freq      = {regs[4][2:0], regs[3]};
    assign sq1_lenEnable = regs[4][LEN_EN_BIT];
    assign sq1_trig      = trig_q[0];

    assign sq2_duty      = regs[6][7:6];
    assign sq2_lenLoad   = regs[6][5:0];
    assign sq2_startVol  = regs[7][7:4];
    assign sq2_envAdd    = regs[7][3];
    assign sq2_period    = regs[7][2:0];
    assign sq2_freq      = {regs[9][2:0], regs[8]};
    assign sq2_lenEnable = regs[9][LEN_EN_BIT];
    assign sq2_trig      = trig_q[1];

    assign w_enable      = regs[10][7];
    assign w_lenLoad     = regs[11][5:0];
    assign w_vol         = regs[12][6:5];
    assign w_freq        = {regs[14][2:0], regs[13]};
    assign w_lenEnable   = regs[14][LEN_EN_BIT];
    assign w_trig        = trig_q[2];

    assign n_lenLoad     = regs[16][5:0];
    assign n_startVol    = regs[17][7:4];
    assign n_envAdd      = regs[17][3];
    assign n_period      = regs[17][2:0];
    assign n_clkShift    = regs[18][7:4];
    assign n_widthMode   = regs[18][3];
    assign n_divisor     = regs[18][2:0];
    assign n_lenEnable   = regs[19][LEN_EN_BIT];
    assign n_trig        = trig_q[3];

    assign volL          = regs[20][6:4];
    assign volR          = regs[20][2:0];
    assign pan           = regs[21];

endmodule
